stress_sched: RTL and testbench
===============================

// Module: stress_sched
// PURPOSE
//  Time-multiplexes NCH external stress-pattern generators (one per SP/toggle setting) onto one DUT stress line.
//  Each slot is STRESS (dwell), then RELAX (line held 0), then a MEAS handshake with the in-situ sensor readout.
//  Channels are visited round-robin over an enabled mask. Sits between the stress-generator bank and the DUT/monitor.
// PARAMETERS
//  NCH       4   number of stress generator inputs (2..16)
//  DWELL_W   16  width of dwell_len / dwell counter
//  RELAX_CYC 8   cycles stress_o is forced 0 before each measurement (>=1)
//  TIMEOUT   255 meas_ack watchdog limit in cycles (used only with STRESS_SCHED_TIMEOUT_EN)
// PORTS
//  clk         in   1             clock
//  rst         in   1             synchronous reset, active-high
//  start       in   1             1-cycle request to begin a schedule (honoured only in IDLE)
//  stop        in   1             abort; returns to IDLE next cycle from any state
//  ch_mask     in   NCH           enabled channels, latched on accepted start
//  dwell_len   in   DWELL_W       STRESS cycles per slot, latched on start; 0 treated as 1
//  num_slots   in   8             slots to run, latched on start; 0 = run until stop
//  stress_in   in   NCH           stress waveforms from generator bank
//  meas_ack    in   1             sensor readout complete
//  stress_o    out  1             registered stress to DUT
//  ch_sel      out  $clog2(NCH)   channel of current/last slot
//  meas_req    out  1             high in MEAS until ack
//  busy        out  1             high in any state except IDLE
//  done        out  1             1-cycle pulse when num_slots completed
//  slot_cnt    out  8             completed slots since start (wraps 255->0 when num_slots=0)
//  cfg_err     out  1             1-cycle pulse: start rejected (ch_mask==0)
//  timeout_err out  1             sticky watchdog flag
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; ch_sel=0; internal last-channel pointer = NCH-1 (first pick searches from ch 0).
//  FSM: IDLE -> SELECT -> STRESS -> RELAX -> MEAS -> SELECT ... -> IDLE.
//  IDLE: start & ~stop & |ch_mask -> latch cfg, clear slot_cnt, SELECT next cycle. start & ch_mask==0 -> cfg_err, stay.
//   start & stop same cycle -> stop wins, nothing latched. start while busy ignored.
//  SELECT (1 cycle): ch_sel <= first set bit of latched mask strictly after last pointer, wrapping modulo NCH;
//   with a single enabled channel the same channel is reselected. -> STRESS.
//  STRESS: exactly max(dwell_len,1) cycles; stress_o(t+1) = stress_in[ch_sel](t) (1-cycle register latency).
//  RELAX: exactly RELAX_CYC cycles; stress_o=0 throughout (first 0 appears in first RELAX cycle).
//  MEAS: meas_req=1, stress_o=0; meas_ack sampled high -> meas_req falls next cycle, slot_cnt+1, last pointer=ch_sel.
//   Then if num_slots!=0 and slot_cnt+1==num_slots -> IDLE with done pulse coincident with busy falling;
//   else -> SELECT. meas_ack outside MEAS is ignored.
//  stop (any non-IDLE state): next cycle IDLE, stress_o=0, meas_req=0, no done pulse, slot_cnt holds last value.
//  rst mid-schedule: identical to reset values; latched config discarded.
//  Slot period (no wait on ack) = 1 + dwell + RELAX_CYC + 1 cycles.
// CONFIGURATION
//  STRESS_SCHED_TIMEOUT_EN defined: MEAS counter; if ack absent for TIMEOUT cycles, timeout_err set (sticky until rst
//   or accepted start), slot counted as completed, FSM proceeds as if acked.
//  Not defined: MEAS waits indefinitely for meas_ack; timeout_err tied 0; no watchdog counter.
// TESTING
//  1 mask=4'b1011, dwell=5, num_slots=6, ack 2 cycles after req -> ch_sel 0,1,3,0,1,3; done once; slot_cnt=6.
//  2 stress_in[1] toggling each cycle, ch 1 slot, dwell=4 -> stress_o equals stress_in[1] delayed 1 for 4 cycles,
//    then 0 for 8 RELAX cycles.
//  3 start with ch_mask=0 -> cfg_err 1 cycle, busy stays 0; start&stop together -> busy stays 0.
//  4 stop asserted in STRESS of slot 2 -> IDLE next cycle, stress_o=0, no done, slot_cnt=1.
//  5 dwell_len=0, num_slots=1, mask=4'b0100 -> STRESS 1 cycle on ch 2, done 12 cycles after start (ack immediate).
//  6 TIMEOUT_EN, TIMEOUT=16, meas_ack never -> timeout_err set after 16 MEAS cycles, next slot begins; without
//    macro FSM stays in MEAS with meas_req=1.

Source files
------------

// File: rtl/stress_sched.sv
// stress_sched: round-robin scheduler muxing NCH stress generators onto one DUT line.
// Optional watchdog on meas_ack enabled by defining STRESS_SCHED_TIMEOUT_EN.
module stress_sched #(
  parameter int NCH       = 4,
  parameter int DWELL_W   = 16,
  parameter int RELAX_CYC = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [NCH-1:0]         ch_mask,
  input  logic [DWELL_W-1:0]     dwell_len,
  input  logic [7:0]             num_slots,
  input  logic [NCH-1:0]         stress_in,
  input  logic                   meas_ack,
  output logic                   stress_o,
  output logic [$clog2(NCH)-1:0] ch_sel,
  output logic                   meas_req,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             slot_cnt,
  output logic                   cfg_err,
  output logic                   timeout_err
);

  localparam int CW = $clog2(NCH);
  localparam int RW = $clog2(RELAX_CYC) + 1;
  localparam logic [RW-1:0] RLAST = RW'(RELAX_CYC - 1);
  localparam logic [DWELL_W-1:0] D1 = DWELL_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    STRESS,
    RELAX,
    MEAS
  } state_t;

  state_t state, state_n;

  logic [NCH-1:0]     mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dcnt;
  logic [7:0]         slots_q;
  logic [CW-1:0]      last_q;
  logic [CW-1:0]      pick;
  logic [CW-1:0]      idx;
  logic [CW-1:0]      ch_n;
  logic [RW-1:0]      rcnt;
  logic               accept;
  logic               ack_ok;
  logic               slot_end;
  logic               fin;
  logic               tmo;

  assign accept   = (state == IDLE) & start & ~stop & (|ch_mask);
  assign busy     = (state != IDLE);
  assign meas_req = (state == MEAS);
  assign ack_ok   = meas_ack | tmo;

`ifdef STRESS_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tcnt;

  assign tmo = (state == MEAS) & ~meas_ack
             & (tcnt == TW'(TIMEOUT - 1));

  // Watchdog counts consecutive MEAS cycles without an ack
  always_ff @(posedge clk) begin
    if (rst)
      tcnt <= '0;
    else if (state == MEAS && state_n == MEAS)
      tcnt <= tcnt + TW'(1);
    else
      tcnt <= '0;
  end

  // Sticky timeout flag, cleared by a new accepted schedule
  always_ff @(posedge clk) begin
    if (rst)
      timeout_err <= 1'b0;
    else if (accept)
      timeout_err <= 1'b0;
    else if (tmo && !stop)
      timeout_err <= 1'b1;
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next enabled channel strictly after last_q, wrapping; descending scan
  // leaves the nearest candidate as the final assignment
  always_comb begin
    pick = last_q;
    idx  = last_q;
    for (int i = NCH; i >= 1; i--) begin
      idx = CW'((int'(last_q) + i) % NCH);
      if (mask_q[idx])
        pick = idx;
    end
  end

  // Next-state and slot-completion decode; stop overrides everything
  always_comb begin
    state_n  = state;
    ch_n     = ch_sel;
    fin      = 1'b0;
    slot_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept)
          state_n = SELECT;
      end
      SELECT: begin
        ch_n    = pick;
        state_n = STRESS;
      end
      STRESS: begin
        if (dcnt == dwell_q - D1)
          state_n = RELAX;
      end
      RELAX: begin
        if (rcnt == RLAST)
          state_n = MEAS;
      end
      MEAS: begin
        if (ack_ok) begin
          slot_end = 1'b1;
          if (slots_q != 8'd0 && slot_cnt + 8'd1 == slots_q) begin
            fin     = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = SELECT;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (stop && state != IDLE) begin
      state_n  = IDLE;
      ch_n     = ch_sel;
      fin      = 1'b0;
      slot_end = 1'b0;
    end
  end

  // State register plus registered output pulses and stress line
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ch_sel   <= '0;
      stress_o <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_n;
      ch_sel   <= ch_n;
      stress_o <= (state_n == STRESS) & stress_in[ch_n];
      done     <= fin;
      cfg_err  <= (state == IDLE) & start & ~stop & ~(|ch_mask);
    end
  end

  // Dwell and relax counters restart whenever their state is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
      rcnt <= '0;
    end else begin
      if (state == STRESS && state_n == STRESS)
        dcnt <= dcnt + D1;
      else
        dcnt <= '0;
      if (state == RELAX && state_n == RELAX)
        rcnt <= rcnt + RW'(1);
      else
        rcnt <= '0;
    end
  end

  // Latched configuration, slot counter and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q   <= '0;
      dwell_q  <= D1;
      slots_q  <= 8'd0;
      slot_cnt <= 8'd0;
      last_q   <= CW'(NCH - 1);
    end else if (accept) begin
      mask_q   <= ch_mask;
      dwell_q  <= (dwell_len == '0) ? D1 : dwell_len;
      slots_q  <= num_slots;
      slot_cnt <= 8'd0;
    end else if (slot_end) begin
      slot_cnt <= slot_cnt + 8'd1;
      last_q   <= ch_sel;
    end
  end

endmodule

// File: tb/tb_stress_sched.sv
// tb_stress_sched: timeline-model bench for stress_sched.
// Expected outputs derive from slot position, not from the DUT state.
module tb_stress_sched;

  localparam int NCH = 4;
  localparam int RLX = 8;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           stop;
  logic [NCH-1:0] ch_mask;
  logic [15:0]    dwell_len;
  logic [7:0]     num_slots;
  logic [NCH-1:0] stress_in;
  logic           meas_ack;
  logic           stress_o;
  logic [1:0]     ch_sel;
  logic           meas_req;
  logic           busy;
  logic           done;
  logic [7:0]     slot_cnt;
  logic           cfg_err;
  logic           timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int last_ch = NCH - 1;
  bit tmo_model = 1'b0;

  stress_sched #(
    .NCH(NCH), .DWELL_W(16), .RELAX_CYC(RLX), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .ch_mask(ch_mask), .dwell_len(dwell_len),
    .num_slots(num_slots), .stress_in(stress_in),
    .meas_ack(meas_ack), .stress_o(stress_o),
    .ch_sel(ch_sel), .meas_req(meas_req), .busy(busy),
    .done(done), .slot_cnt(slot_cnt), .cfg_err(cfg_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lowest enabled channel above 'last', else lowest enabled overall
  function automatic int next_ch(input logic [NCH-1:0] m, input int last);
    int first = -1;
    int nxt = -1;
    for (int i = 0; i < NCH; i++) begin
      if (m[i]) begin
        if (first < 0) first = i;
        if (i > last && nxt < 0) nxt = i;
      end
    end
    return (nxt >= 0) ? nxt : first;
  endfunction

  task automatic chk_idle(input string tag, input int sc);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_so"}, stress_o, 0);
    chk({tag, "_req"}, meas_req, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_scnt"}, slot_cnt, sc);
  endtask

  // ackd: MEAS cycles before ack (-1 = never). stop at (stop_s, stop_c).
  task automatic run_sched(input logic [NCH-1:0] m, input int dw,
                           input int ns, input int nrun, input int ackd,
                           input int stop_s, input int stop_c);
    int d, ch, meas0, p;
    bit fstop;
    logic exp_so;
    d = (dw == 0) ? 1 : dw;
    ch_mask = m;
    dwell_len = 16'(dw);
    num_slots = 8'(ns);
    start = 1'b1;
    stop = 1'b0;
    meas_ack = 1'b0;
    step();
    start = 1'b0;
    tmo_model = 1'b0;
    for (int s = 0; s < nrun; s++) begin
      ch = next_ch(m, last_ch);
      meas0 = d + RLX + 1;
`ifdef STRESS_SCHED_TIMEOUT_EN
      p = (ackd < 0) ? meas0 + TMO : meas0 + ackd + 1;
`else
      p = (ackd < 0) ? meas0 + 20 : meas0 + ackd + 1;
`endif
      for (int c = 0; c < p; c++) begin
        chk("busy", busy, 1);
        chk("slot_cnt", slot_cnt, s);
        chk("done", done, 0);
        chk("cfg_err", cfg_err, 0);
        chk("timeout_err", timeout_err, 32'(tmo_model));
        if (c >= 1) chk("ch_sel", ch_sel, ch);
        exp_so = (c >= 1 && c <= d) ? stress_in[ch] : 1'b0;
        chk("stress_o", stress_o, exp_so);
        chk("meas_req", meas_req, (c >= meas0) ? 1 : 0);
        fstop = (s == stop_s && c == stop_c);
`ifndef STRESS_SCHED_TIMEOUT_EN
        if (ackd < 0 && c == p - 1) fstop = 1'b1;
`endif
        if (fstop) begin
          stop = 1'b1;
          meas_ack = 1'b0;
          step();
          stop = 1'b0;
          start = 1'b0;
          chk_idle("stop", s);
          return;
        end
        if (c >= meas0)
          meas_ack = (ackd >= 0 && c == meas0 + ackd);
        else
          meas_ack = 1'($urandom);
        start = ($urandom_range(0, 3) == 0);
        ch_mask = NCH'($urandom);
        dwell_len = 16'($urandom);
        num_slots = 8'($urandom);
        stress_in = NCH'($urandom);
        step();
      end
      last_ch = ch;
      if (ackd < 0) tmo_model = 1'b1;
    end
    start = 1'b0;
    meas_ack = 1'b0;
    if (ns != 0 && nrun == ns) begin
      chk("end_busy", busy, 0);
      chk("end_done", done, 1);
      chk("end_scnt", slot_cnt, ns);
      chk("end_req", meas_req, 0);
      chk("end_so", stress_o, 0);
      chk("end_tmo", timeout_err, 32'(tmo_model));
      step();
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
    end else begin
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk_idle("runstop", nrun);
    end
  endtask

  initial begin
    int m, dw, ns, ad, ss, sc;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    ch_mask = '0;
    dwell_len = '0;
    num_slots = '0;
    stress_in = '0;
    meas_ack = 1'b0;
    repeat (3) step();
    chk_idle("rst", 0);
    chk("rst_ch", ch_sel, 0);
    chk("rst_cfg", cfg_err, 0);
    chk("rst_tmo", timeout_err, 0);
    rst = 1'b0;
    step();

    run_sched(4'b1011, 5, 6, 6, 2, -1, -1);
    run_sched(4'b0010, 4, 1, 1, 1, -1, -1);

    ch_mask = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("cfg_err_on", cfg_err, 1);
    chk("cfg_busy", busy, 0);
    step();
    chk("cfg_err_off", cfg_err, 0);
    chk("cfg_busy2", busy, 0);

    ch_mask = 4'b1111;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_cfg", cfg_err, 0);
    step();
    chk("ss_busy2", busy, 0);

    run_sched(4'b1111, 6, 5, 5, 1, 1, 3);
    run_sched(4'b0100, 0, 1, 1, 0, -1, -1);
    run_sched(4'b1000, 3, 3, 3, 1, -1, -1);
    run_sched(4'b0101, 2, 0, 3, 1, -1, -1);

    for (int it = 0; it < 8; it++) begin
      m = $urandom_range(1, 15);
      dw = $urandom_range(0, 6);
      ns = $urandom_range(1, 4);
      ad = $urandom_range(0, 3);
      ss = -1;
      sc = -1;
      if (it % 3 == 2) begin
        ss = $urandom_range(0, ns - 1);
        sc = $urandom_range(0, (dw == 0) ? 1 : dw);
      end
      run_sched(NCH'(m), dw, ns, ns, ad, ss, sc);
    end

    ch_mask = 4'b0110;
    dwell_len = 16'd3;
    num_slots = 8'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("mrst", 0);
    chk("mrst_ch", ch_sel, 0);
    chk("mrst_cfg", cfg_err, 0);
    last_ch = NCH - 1;
    tmo_model = 1'b0;
    step();

    run_sched(4'b1110, 1, 2, 2, 0, -1, -1);
    run_sched(4'b0001, 2, 2, 2, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
